noise_gate: RTL

- Sample-strobed noise gate that sits directly upstream of the distortion stage.
- Suppresses pickup hiss and hum before gain multiplies it.
- Tracks a peak envelope and runs an attack/open/hold/release state machine that ramps a fixed-point gate gain.
- Output is the input scaled by that gain, registered, with a valid strobe; it feeds the distortion input directly.

---
 rtl/noise_gate_pkg.sv | 47 ++++
 rtl/noise_gate_if.sv | 38 +++
 rtl/noise_gate_envelope.sv | 45 ++++
 rtl/noise_gate.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/noise_gate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noise_gate_pkg
//  Description : Shared types and helpers for the noise gate. Holds the gate
//                state encoding, the default gain resolution with its unity
//                constant, and the saturating absolute-value helper used by
//                the envelope follower.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package noise_gate_pkg;

    // Default fractional bits of the gate gain.
    localparam int c_BITS_PER_LEVEL = 12;

    // Gate state encoding, fixed 3-bit width.
    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_OPEN    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } gate_state_t;

    // Unity gain for a given number of fractional bits.
    function automatic int gain_unity(input int bits);
        return 1 << bits;
    endfunction

    localparam int c_UNITY = gain_unity(c_BITS_PER_LEVEL);

    // |x| on a signed 16-bit sample; -32768 has no positive counterpart and
    // saturates to 32767 so the envelope stays a clean unsigned 16-bit value.
    function automatic logic [15:0] abs_sat16(input logic signed [15:0] x);
        logic [15:0] r;
        if (x == 16'sh8000) begin
            r = 16'h7FFF;
        end else if (x < 0) begin
            r = $unsigned(-x);
        end else begin
            r = $unsigned(x);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noise_gate_if.sv
`default_nettype none
// ============================================================================
//  Module      : noise_gate_if
//  Description : Sample stream bundle around the noise gate: strobed input
//                sample, strobed gated output sample and the gate status.
//  Ports       : in_valid / in_signal   - sample strobe and signed sample
//                out_valid / out_signal - output strobe and gated sample
//                gate_open              - registered gate status
//                modport master: drives the input sample, observes outputs
//                modport slave : the gate itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface noise_gate_if;

    logic               in_valid;
    logic signed [15:0] in_signal;
    logic               out_valid;
    logic signed [15:0] out_signal;
    logic               gate_open;

    modport master (
        output in_valid,
        output in_signal,
        input  out_valid,
        input  out_signal,
        input  gate_open
    );

    modport slave (
        input  in_valid,
        input  in_signal,
        output out_valid,
        output out_signal,
        output gate_open
    );

endinterface
`default_nettype wire

// File: rtl/noise_gate_envelope.sv
`default_nettype none
// ============================================================================
//  Module      : envelope_follower
//  Description : Peak envelope tracker. The envelope jumps instantly to the
//                sample magnitude and decays exponentially by
//                env >> DECAY_SHIFT per accepted sample.
//  Ports       : clk, rst    - clock, asynchronous active-high reset
//                in_valid    - sample strobe; envelope register updates only
//                              on strobe cycles
//                in_signal   - signed 16-bit sample
//                env_next    - envelope value for the current sample
//                              (combinational, valid while in_valid is high)
//  Revision    : 1.0 - initial release
// ============================================================================
module envelope_follower
    import noise_gate_pkg::*;
#(
    parameter int DECAY_SHIFT = 4
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               in_valid,
    input  wire signed [15:0] in_signal,
    output logic       [15:0] env_next
);

    logic [15:0] r_env;
    logic [15:0] w_mag;
    logic [15:0] w_decayed;

    assign w_mag     = abs_sat16(in_signal);
    // Never underflows: the subtracted term is at most r_env itself.
    assign w_decayed = r_env - (r_env >> DECAY_SHIFT);
    assign env_next  = (w_mag > w_decayed) ? w_mag : w_decayed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_env <= '0;
        end else if (in_valid) begin
            r_env <= env_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/noise_gate.sv
`default_nettype none
// ============================================================================
//  Module      : noise_gate
//  Description : Sample-strobed noise gate ahead of the distortion stage.
//                A peak envelope drives a CLOSED/ATTACK/OPEN/HOLD/RELEASE
//                state machine that ramps a fixed-point gain; each accepted
//                sample is scaled by the new gain and registered.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                bus (slave)   - in_valid/in_signal in,
//                                out_valid/out_signal/gate_open out
//                thr_open      - envelope level that opens the gate
//                thr_close     - envelope level below which closing starts
//                hold_samples  - samples held open after env < thr_close
//                attack_step   - gain increment per sample while attacking
//                release_step  - gain decrement per sample while releasing
//  Revision    : 1.0 - initial release
// ============================================================================
module noise_gate
    import noise_gate_pkg::*;
#(
    parameter int BITS_PER_LEVEL = c_BITS_PER_LEVEL,
    parameter int DECAY_SHIFT    = 4,
    parameter int HOLD_WIDTH     = 16
) (
    input  wire                  clk,
    input  wire                  rst,
    noise_gate_if.slave          bus,
    input  wire [15:0]           thr_open,
    input  wire [15:0]           thr_close,
    input  wire [HOLD_WIDTH-1:0] hold_samples,
    input  wire [15:0]           attack_step,
    input  wire [15:0]           release_step
);

    // Gain spans 0..unity inclusive, so one bit above the fraction.
    localparam int c_GW = BITS_PER_LEVEL + 1;
    // Step arithmetic width: wide enough for gain + 16-bit step without wrap.
    localparam int c_SW = ((c_GW > 16) ? c_GW : 16) + 1;
    localparam logic [c_GW-1:0] c_GAIN_ONE = c_GW'(gain_unity(BITS_PER_LEVEL));

    gate_state_t            r_state;
    gate_state_t            w_state_next;
    logic [c_GW-1:0]        r_gain;
    logic [c_GW-1:0]        w_gain_next;
    logic [HOLD_WIDTH-1:0]  r_hold_cnt;
    logic [HOLD_WIDTH-1:0]  w_hold_next;

    logic [15:0]            w_env_next;
    logic                   w_above_open;
    logic                   w_below_close;

    logic [c_SW-1:0]        w_gain_sum;
    logic [c_GW-1:0]        w_gain_inc;
    logic [c_GW-1:0]        w_gain_dec;

    logic signed [31:0]     w_sample_ext;
    logic signed [31:0]     w_gain_ext;
    logic signed [31:0]     w_product;
    logic signed [15:0]     w_out_next;

    logic                   r_out_valid;
    logic signed [15:0]     r_out_signal;
    logic                   r_gate_open;

    // ------------------------------------------------------------------
    // Envelope
    // ------------------------------------------------------------------
    envelope_follower #(
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_env (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_signal (bus.in_signal),
        .env_next  (w_env_next)
    );

    // Decisions look at this sample's envelope, not last sample's.
    assign w_above_open  = (w_env_next >= thr_open);
    assign w_below_close = (w_env_next <  thr_close);

    // ------------------------------------------------------------------
    // Gain ramp candidates (saturating at unity and at zero)
    // ------------------------------------------------------------------
    assign w_gain_sum = c_SW'(r_gain) + c_SW'(attack_step);
    assign w_gain_inc = (w_gain_sum >= c_SW'(c_GAIN_ONE)) ? c_GAIN_ONE
                                                          : w_gain_sum[c_GW-1:0];
    assign w_gain_dec = (c_SW'(release_step) >= c_SW'(r_gain))
                        ? '0
                        : c_GW'(c_SW'(r_gain) - c_SW'(release_step));

    // ------------------------------------------------------------------
    // State machine: next state, next gain, next hold count
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_gain_next  = r_gain;
        w_hold_next  = r_hold_cnt;

        unique case (r_state)
            ST_CLOSED: begin
                if (w_above_open) begin
                    w_state_next = ST_ATTACK;
                    w_gain_next  = w_gain_inc;
                end
            end

            ST_ATTACK: begin
                if (w_below_close) begin
                    // Gain is left where it is; RELEASE ramps it down next.
                    w_state_next = ST_RELEASE;
                end else begin
                    w_gain_next = w_gain_inc;
                    if (w_gain_inc == c_GAIN_ONE) begin
                        w_state_next = ST_OPEN;
                    end
                end
            end

            ST_OPEN: begin
                w_gain_next = c_GAIN_ONE;
                if (w_below_close) begin
                    if (hold_samples == '0) begin
                        // No hold time: the first decrement lands this sample.
                        w_state_next = ST_RELEASE;
                        w_gain_next  = w_gain_dec;
                    end else begin
                        w_state_next = ST_HOLD;
                        w_hold_next  = hold_samples;
                    end
                end
            end

            ST_HOLD: begin
                w_gain_next = c_GAIN_ONE;
                if (!w_below_close) begin
                    w_state_next = ST_OPEN;
                end else begin
                    w_hold_next = r_hold_cnt - HOLD_WIDTH'(1);
                    // Counter hits zero this sample: switch state, but the
                    // gain stays at unity until the next sample.
                    if (r_hold_cnt <= HOLD_WIDTH'(1)) begin
                        w_hold_next  = '0;
                        w_state_next = ST_RELEASE;
                    end
                end
            end

            ST_RELEASE: begin
                if (w_above_open) begin
                    // Re-trigger ramps up from wherever the gain currently is.
                    w_state_next = ST_ATTACK;
                    w_gain_next  = w_gain_inc;
                end else begin
                    w_gain_next = w_gain_dec;
                    if (w_gain_dec == '0) begin
                        w_state_next = ST_CLOSED;
                    end
                end
            end

            default: begin
                w_state_next = ST_CLOSED;
                w_gain_next  = '0;
                w_hold_next  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Gain multiply: 32-bit signed product, arithmetic shift (floor).
    // Gain never exceeds unity, so the shifted result fits in 16 bits.
    // ------------------------------------------------------------------
    assign w_sample_ext = 32'(bus.in_signal);
    assign w_gain_ext   = 32'(w_gain_next);
    assign w_product    = w_sample_ext * w_gain_ext;
    assign w_out_next   = 16'(w_product >>> BITS_PER_LEVEL);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_CLOSED;
            r_gain     <= '0;
            r_hold_cnt <= '0;
        end else if (bus.in_valid) begin
            r_state    <= w_state_next;
            r_gain     <= w_gain_next;
            r_hold_cnt <= w_hold_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_signal <= '0;
            r_gate_open  <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_out_signal <= w_out_next;
                r_gate_open  <= (w_state_next != ST_CLOSED);
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_signal = r_out_signal;
    assign bus.gate_open  = r_gate_open;

endmodule
`default_nettype wire
